// File: rtl/fp_accum_pkg.sv
// Shared floating-point definitions for the accumulator slice.
// Binary32-style layout: sign, biased exponent, stored mantissa.
package fp_accum_pkg;

    localparam int FP_EXP_BITS  = 8;
    localparam int FP_MANT_BITS = 23;

    typedef struct packed {
        logic                    sign;
        logic [FP_EXP_BITS-1:0]  exp;
        logic [FP_MANT_BITS-1:0] mant;
    } fp_t;

    // Zero exponent means zero here; subnormals are flushed.
    function automatic logic fp_is_zero(input fp_t x);
        return x.exp == '0;
    endfunction

endpackage

// File: rtl/fp_accum_add.sv
// Two-cycle floating-point adder: align/add, then normalize/round/pack.
// Round-to-nearest-even, subnormals flushed to zero, overflow saturates to infinity.
module fp_add
    import fp_accum_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_vld,
    input  fp_t  a,
    input  fp_t  b,
    input  logic is_sub,
    output fp_t  sum,
    output logic out_vld
);

    localparam int SIG_W = FP_MANT_BITS + 1;
    localparam int EXT_W = SIG_W + 3;
    localparam int MAG_W = EXT_W + 1;
    localparam int EW    = FP_EXP_BITS + 3;

    localparam logic [FP_EXP_BITS-1:0] EXT_WE = FP_EXP_BITS'(EXT_W);
    localparam logic signed [EW-1:0]   E_MAX  = EW'((1 << FP_EXP_BITS) - 1);
    localparam logic signed [EW-1:0]   E_ZERO = '0;
    localparam logic signed [EW-1:0]   E_ONE  = EW'(1);

    function automatic int lead_zeros(input logic [EXT_W-1:0] v);
        int n;
        n = EXT_W;
        for (int i = 0; i < EXT_W; i++) begin
            if (v[i]) n = EXT_W - 1 - i;
        end
        return n;
    endfunction

    // Low three bits of v are guard, round and sticky.
    function automatic logic [SIG_W:0] round_rne(input logic [EXT_W-1:0] v);
        logic up;
        up = v[2] & ((|v[1:0]) | v[3]);
        return {1'b0, v[EXT_W-1:3]} + {{SIG_W{1'b0}}, up};
    endfunction

    function automatic fp_t pack_sat(input logic s, input logic signed [EW-1:0] e,
                                     input logic [SIG_W-1:0] sig);
        fp_t r;
        if (e >= E_MAX)
            r = {s, {FP_EXP_BITS{1'b1}}, {FP_MANT_BITS{1'b0}}};
        else if (e <= E_ZERO)
            r = '0;
        else
            r = {s, e[FP_EXP_BITS-1:0], sig[SIG_W-2:0]};
        return r;
    endfunction

    fp_t                    b_eff, lrg, sml;
    logic [SIG_W-1:0]       sig_l, sig_s;
    logic [FP_EXP_BITS-1:0] diff;
    logic [EXT_W-1:0]       ext_s, shf_s, mask;
    logic                   sticky;
    logic [MAG_W-1:0]       mag_c;

    always_comb begin
        b_eff      = b;
        b_eff.sign = b.sign ^ is_sub;
        if ({b.exp, b.mant} > {a.exp, a.mant}) begin
            lrg = b_eff;
            sml = a;
        end else begin
            lrg = a;
            sml = b_eff;
        end
        sig_l  = fp_is_zero(lrg) ? '0 : {1'b1, lrg.mant};
        sig_s  = fp_is_zero(sml) ? '0 : {1'b1, sml.mant};
        diff   = lrg.exp - sml.exp;
        ext_s  = {sig_s, 3'b000};
        mask   = '0;
        shf_s  = '0;
        sticky = 1'b0;
        if (diff >= EXT_WE) begin
            sticky = |ext_s;
        end else begin
            shf_s  = ext_s >> diff;
            mask   = (EXT_W'(1) << diff) - EXT_W'(1);
            sticky = |(ext_s & mask);
        end
        shf_s = {shf_s[EXT_W-1:1], shf_s[0] | sticky};
        if (lrg.sign != sml.sign)
            mag_c = {1'b0, sig_l, 3'b000} - {1'b0, shf_s};
        else
            mag_c = {1'b0, sig_l, 3'b000} + {1'b0, shf_s};
    end

    // ---- stage p0: aligned magnitude ----
    logic                   vld_p0;
    logic                   sign_p0;
    logic [FP_EXP_BITS-1:0] exp_p0;
    logic [MAG_W-1:0]       mag_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_p0 <= 1'b0;
        else     vld_p0 <= in_vld;
    end

    always_ff @(posedge clk) begin
        sign_p0 <= lrg.sign;
        exp_p0  <= lrg.exp;
        mag_p0  <= mag_c;
    end

    logic [EXT_W-1:0]       norm;
    logic signed [EW-1:0]   e_n;
    logic [SIG_W:0]         rnd;
    logic [SIG_W-1:0]       sig_n;
    int                     lz;
    fp_t                    sum_c;

    always_comb begin
        lz  = 0;
        e_n = signed'({3'b000, exp_p0});
        if (mag_p0[MAG_W-1]) begin
            norm = {mag_p0[MAG_W-1:2], |mag_p0[1:0]};
            e_n  = e_n + E_ONE;
        end else begin
            lz   = lead_zeros(mag_p0[EXT_W-1:0]);
            norm = mag_p0[EXT_W-1:0] << lz;
            e_n  = e_n - EW'(lz);
        end
        rnd = round_rne(norm);
        if (rnd[SIG_W]) begin
            sig_n = rnd[SIG_W:1];
            e_n   = e_n + E_ONE;
        end else begin
            sig_n = rnd[SIG_W-1:0];
        end
        // Any exact cancellation packs to +0.
        sum_c = (mag_p0 == '0) ? '0 : pack_sat(sign_p0, e_n, sig_n);
    end

    // ---- stage p1: packed result ----
    logic vld_p1;
    fp_t  sum_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= vld_p0;
    end

    always_ff @(posedge clk) begin
        sum_p1 <= sum_c;
    end

    assign sum     = sum_p1;
    assign out_vld = vld_p1;

endmodule

// File: rtl/fp_accum.sv
// Packet floating-point accumulator: sums elements between first/last markers
// through one shared two-cycle adder and presents sum and element count.
module fp_accum
    import fp_accum_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  fp_t                in_data,
    input  logic               in_first,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output fp_t                out_sum,
    output logic [COUNT_W-1:0] out_count
);

    typedef enum logic [2:0] {IDLE, RUN, ADD1, ADD2, OUT} state_t;

    state_t             state, state_nxt;
    fp_t                acc, acc_nxt;
    logic [COUNT_W-1:0] count, count_nxt;
    logic               last_q, last_nxt;
    logic               started;
    logic               xfer_in;
    logic               add_go;
    fp_t                add_sum;
    logic               add_vld;

    // Holds in_ready low until the first edge after reset is released.
    assign in_ready  = started && (state == IDLE || state == RUN);
    assign xfer_in   = in_valid && in_ready;
    assign out_valid = (state == OUT);
    assign out_sum   = out_valid ? acc : '0;
    assign out_count = out_valid ? count : '0;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        count_nxt = count;
        last_nxt  = last_q;
        add_go    = 1'b0;
        case (state)
            IDLE: begin
                if (xfer_in) begin
                    acc_nxt   = in_data;
                    count_nxt = COUNT_W'(1);
                    state_nxt = in_last ? OUT : RUN;
                end
            end
            RUN: begin
                if (xfer_in) begin
                    if (in_first) begin
                        acc_nxt   = in_data;
                        count_nxt = COUNT_W'(1);
                        state_nxt = in_last ? OUT : RUN;
                    end else begin
                        add_go    = 1'b1;
                        last_nxt  = in_last;
                        count_nxt = (&count) ? count : count + COUNT_W'(1);
                        state_nxt = ADD1;
                    end
                end
            end
            ADD1: state_nxt = ADD2;
            ADD2: begin
                if (add_vld) acc_nxt = add_sum;
                state_nxt = last_q ? OUT : RUN;
            end
            OUT: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            count   <= '0;
            last_q  <= 1'b0;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            count   <= count_nxt;
            last_q  <= last_nxt;
            started <= 1'b1;
        end
    end

    fp_add u_add (
        .clk    (clk),
        .rst    (rst),
        .in_vld (add_go),
        .a      (acc),
        .b      (in_data),
        .is_sub (1'b0),
        .sum    (add_sum),
        .out_vld(add_vld)
    );

endmodule

// File: tb/tb_fp_accum.sv
// Randomized and directed bench for fp_accum against a real-valued packet model.
module tb_fp_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_first, in_last;
    logic        out_valid, out_ready;
    logic [31:0] in_data, out_sum;
    logic [15:0] out_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_accum #(.COUNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_first (in_first),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_count(out_count)
    );

    // Encode an exactly representable real into binary32 bits.
    function automatic logic [31:0] r2b(input real r);
        real  m;
        int   e;
        int   f;
        logic s;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        f = $rtoi((m - 1.0) * 8388608.0);
        return {s, e[7:0], f[22:0]};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic f, input logic l, output bit ok);
        in_valid = 1'b1; in_data = d; in_first = f; in_last = l;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                tick(1);
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_out(output int lat, output bit ok);
        ok  = 1'b0;
        lat = 1;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin ok = 1'b1; break; end
            tick(1);
            lat++;
        end
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (out_sum !== 32'h0 || out_count !== 16'h0) begin errors++; $display("FAIL rst_outputs got %h/%0d want 0/0", out_sum, out_count); end
        tick(2);
        rst = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_release_early got %b want 0", in_ready); end
        tick(1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        bit ok1, ok2, ok3, oko; int lat;
        send(r2b(1.0), 1'b1, 1'b0, ok1);
        send(r2b(2.0), 1'b0, 1'b0, ok2);
        send(r2b(3.0), 1'b0, 1'b1, ok3);
        checks++; if (out_valid !== 1'b0 || out_sum !== 32'h0) begin errors++; $display("FAIL basic_add1_zero got %b/%h want 0/0", out_valid, out_sum); end
        wait_out(lat, oko);
        checks++; if (!(ok1 && ok2 && ok3 && oko)) begin errors++; $display("FAIL basic_timeout got %b%b%b%b want 1111", ok1, ok2, ok3, oko); end
        checks++; if (lat != 3) begin errors++; $display("FAIL basic_latency got %0d want 3", lat); end
        checks++; if (out_sum !== r2b(6.0)) begin errors++; $display("FAIL basic_sum got %h want %h", out_sum, r2b(6.0)); end
        checks++; if (out_count !== 16'd3) begin errors++; $display("FAIL basic_count got %0d want 3", out_count); end
        take_out();
    endtask

    task automatic test_single();
        bit ok1, oko; int lat;
        send(r2b(5.0), 1'b1, 1'b1, ok1);
        wait_out(lat, oko);
        checks++; if (!(ok1 && oko)) begin errors++; $display("FAIL single_timeout got %b%b want 11", ok1, oko); end
        checks++; if (lat != 1) begin errors++; $display("FAIL single_latency got %0d want 1", lat); end
        checks++; if (out_sum !== r2b(5.0) || out_count !== 16'd1) begin errors++; $display("FAIL single_result got %h/%0d want %h/1", out_sum, out_count, r2b(5.0)); end
        take_out();
    endtask

    task automatic test_zeros();
        bit ok1, ok2, oko; int lat;
        send(32'h0, 1'b1, 1'b0, ok1);
        send(32'h0, 1'b0, 1'b1, ok2);
        wait_out(lat, oko);
        checks++; if (!(ok1 && ok2 && oko)) begin errors++; $display("FAIL zeros_timeout got %b%b%b want 111", ok1, ok2, oko); end
        checks++; if (out_sum !== 32'h0 || out_count !== 16'd2) begin errors++; $display("FAIL zeros_result got %h/%0d want 00000000/2", out_sum, out_count); end
        take_out();
    endtask

    task automatic test_backpressure();
        bit ok1, ok2, oko; int lat;
        send(r2b(2.5), 1'b1, 1'b1, ok1);
        wait_out(lat, oko);
        in_valid = 1'b1; in_data = r2b(9.0); in_first = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== r2b(2.5) || out_count !== 16'd1) begin
                errors++;
                $display("FAIL hold_cycle%0d got v=%b r=%b %h/%0d want v=1 r=0 %h/1", i, out_valid, in_ready, out_sum, out_count, r2b(2.5));
            end
        end
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        take_out();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
        send(r2b(1.0), 1'b1, 1'b1, ok2);
        wait_out(lat, oko);
        checks++; if (!(ok1 && ok2 && oko) || out_sum !== r2b(1.0) || out_count !== 16'd1) begin errors++; $display("FAIL hold_next_packet got %h/%0d want %h/1", out_sum, out_count, r2b(1.0)); end
        take_out();
    endtask

    task automatic test_restart();
        bit ok1, ok2, ok3, oko; int lat;
        send(r2b(4.0), 1'b1, 1'b0, ok1);
        send(r2b(-1.5), 1'b1, 1'b0, ok2);
        send(r2b(0.5), 1'b0, 1'b1, ok3);
        wait_out(lat, oko);
        checks++; if (!(ok1 && ok2 && ok3 && oko)) begin errors++; $display("FAIL restart_timeout got %b%b%b%b want 1111", ok1, ok2, ok3, oko); end
        checks++; if (out_sum !== r2b(-1.0) || out_count !== 16'd2) begin errors++; $display("FAIL restart_result got %h/%0d want %h/2", out_sum, out_count, r2b(-1.0)); end
        take_out();
    endtask

    task automatic test_reset_mid();
        bit ok1, ok2, ok3, ok4, oko; int lat;
        send(r2b(1.0), 1'b1, 1'b0, ok1);
        send(r2b(2.0), 1'b0, 1'b0, ok2);
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got r=%b v=%b want 0/0", in_ready, out_valid); end
        tick(2);
        rst = 1'b0;
        tick(1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", in_ready); end
        send(r2b(7.0), 1'b1, 1'b0, ok3);
        send(r2b(1.0), 1'b0, 1'b1, ok4);
        wait_out(lat, oko);
        checks++; if (!(ok1 && ok2 && ok3 && ok4 && oko)) begin errors++; $display("FAIL midrst_timeout got %b%b%b%b%b want 11111", ok1, ok2, ok3, ok4, oko); end
        checks++; if (out_sum !== r2b(8.0) || out_count !== 16'd2) begin errors++; $display("FAIL midrst_result got %h/%0d want %h/2", out_sum, out_count, r2b(8.0)); end
        take_out();
    endtask

    task automatic test_random();
        for (int p = 0; p < 20; p++) begin
            int  len, cnt, lat, explat;
            real v, acc;
            bit  f, ok, all_ok, oko;
            len    = $urandom_range(1, 6);
            all_ok = 1'b1;
            acc    = 0.0;
            cnt    = 0;
            explat = 1;
            for (int k = 0; k < len; k++) begin
                v = real'(int'($urandom_range(0, 80)) - 40) * 0.25;
                f = (k == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 4) == 0);
                if (k == 0 || f) begin
                    acc = v; cnt = 1; explat = 1;
                end else begin
                    acc = acc + v; cnt++; explat = 3;
                end
                tick($urandom_range(0, 2));
                send(r2b(v), f, (k == len - 1), ok);
                all_ok &= ok;
            end
            wait_out(lat, oko);
            checks++; if (!(all_ok && oko)) begin errors++; $display("FAIL rand%0d_timeout got %b%b want 11", p, all_ok, oko); end
            checks++; if (lat != explat) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", p, lat, explat); end
            tick($urandom_range(0, 3));
            checks++; if (out_sum !== r2b(acc)) begin errors++; $display("FAIL rand%0d_sum got %h want %h", p, out_sum, r2b(acc)); end
            checks++; if (out_count !== 16'(cnt)) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", p, out_count, cnt); end
            take_out();
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_data = 32'h0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_single();
        test_zeros();
        test_backpressure();
        test_restart();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
